// File: rtl/decoder3_8_scan.sv
// rtl/decoder3_8_scan.sv - registered 3-to-8 one-hot select decoder with load port and auto-scan
// Optional build macro: DECODER_INV_OUT_EN (active-low select lines, idle value 8'hFF)
module decoder3_8_scan #(
  parameter int SCAN_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       mode_scan,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  output logic       in_ready,
  output logic [7:0] out,
  output logic [2:0] out_code,
  output logic       out_valid,
  output logic       wrap
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HOLD = 2'd1;
  localparam logic [1:0] SCAN = 2'd2;

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);

`ifdef DECODER_INV_OUT_EN
  localparam logic [7:0] OUT_IDLE = 8'hFF;
`else
  localparam logic [7:0] OUT_IDLE = 8'h00;
`endif

  logic [1:0]    state, state_n;
  logic [2:0]    code_n;
  logic          valid_n;
  logic          wrap_n;
  logic [PW-1:0] prescaler, pre_n;
  logic [7:0]    out_n;

  // Code 0 selects the MSB line, code 7 the LSB line.
  function automatic logic [7:0] decode(input logic [2:0] c);
`ifdef DECODER_INV_OUT_EN
    decode = ~(8'h80 >> c);
`else
    decode = 8'h80 >> c;
`endif
  endfunction

  // Loads are only accepted when not scanning and no scan is requested.
  assign in_ready = en & ~mode_scan & (state != SCAN);

  // Next-state logic; priority is en=0, then mode_scan, then in_valid.
  always_comb begin
    state_n = state;
    code_n  = out_code;
    valid_n = out_valid;
    wrap_n  = 1'b0;
    pre_n   = prescaler;
    if (!en) begin
      state_n = IDLE;
      code_n  = 3'd0;
      valid_n = 1'b0;
      pre_n   = '0;
    end else if (mode_scan) begin
      if (state == SCAN) begin
        if (prescaler == PRE_MAX) begin
          pre_n  = '0;
          code_n = out_code + 3'd1;
          wrap_n = (out_code == 3'd7);
        end else begin
          pre_n = prescaler + PW'(1);
        end
      end else begin
        state_n = SCAN;
        code_n  = 3'd0;
        valid_n = 1'b1;
        pre_n   = '0;
      end
    end else if (state == SCAN) begin
      // Leaving scan freezes the current code; the load port reopens next cycle.
      state_n = HOLD;
      pre_n   = '0;
    end else if (in_valid) begin
      state_n = HOLD;
      code_n  = in_code;
      valid_n = 1'b1;
    end
    out_n = valid_n ? decode(code_n) : OUT_IDLE;
  end

  // All visible outputs are flop outputs so select lines never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out       <= OUT_IDLE;
      out_code  <= 3'd0;
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      prescaler <= '0;
    end else begin
      state     <= state_n;
      out       <= out_n;
      out_code  <= code_n;
      out_valid <= valid_n;
      wrap      <= wrap_n;
      prescaler <= pre_n;
    end
  end

endmodule

// File: tb/tb_decoder3_8_scan.sv
// tb/tb_decoder3_8_scan.sv - scoreboard bench for decoder3_8_scan
module tb_decoder3_8_scan;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode_scan = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in_code = 3'd0;
  logic       in_ready;
  logic [7:0] out;
  logic [2:0] out_code;
  logic       out_valid;
  logic       wrap;

  typedef struct packed {
    logic [7:0] o;
    logic [2:0] c;
    logic       v;
    logic       w;
  } exp_t;

  exp_t       q[$];
  int         n_vec = 0;
  int         n_bad = 0;
  logic [7:0] tbl[8];

  decoder3_8_scan #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .en(en), .mode_scan(mode_scan),
    .in_valid(in_valid), .in_code(in_code), .in_ready(in_ready),
    .out(out), .out_code(out_code), .out_valid(out_valid), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Expected values are written active-high; the inverted build flips them.
  function automatic logic [7:0] pol(input logic [7:0] o);
`ifdef DECODER_INV_OUT_EN
    pol = ~o;
`else
    pol = o;
`endif
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check in_ready, queue the post-edge expectation.
  task automatic step(input logic e, input logic ms, input logic iv, input logic [2:0] c,
                      input logic [7:0] eo, input logic [2:0] ec, input logic ev,
                      input logic ew, input logic er);
    exp_t x;
    @(negedge clk);
    en = e; mode_scan = ms; in_valid = iv; in_code = c;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, er});
    x.o = pol(eo); x.c = ec; x.v = ev; x.w = ew;
    q.push_back(x);
    @(posedge clk);
  endtask

  // Monitor: compare registered outputs against the scoreboard after each edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      n_vec++;
      if (out !== e.o || out_code !== e.c || out_valid !== e.v || wrap !== e.w) begin
        n_bad++;
        $display("FAIL outputs @%0t: got out=%h code=%0d valid=%b wrap=%b, expected out=%h code=%0d valid=%b wrap=%b",
                 $time, out, out_code, out_valid, wrap, e.o, e.c, e.v, e.w);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t x;
    tbl[0] = 8'h80; tbl[1] = 8'h40; tbl[2] = 8'h20; tbl[3] = 8'h10;
    tbl[4] = 8'h08; tbl[5] = 8'h04; tbl[6] = 8'h02; tbl[7] = 8'h01;

    #1;
    chk("reset_out", {24'd0, out}, {24'd0, pol(8'h00)});
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_code", {29'd0, out_code}, 32'd0);
    chk("reset_wrap", {31'd0, wrap}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Single load of code 5, then hold.
    step(1, 0, 1, 3'd5, 8'h04, 3'd5, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd1, 8'h04, 3'd5, 1, 0, 1);

    // Back-to-back loads 0..7.
    for (int i = 0; i < 8; i++) step(1, 0, 1, 3'(i), tbl[i], 3'(i), 1, 0, 1);

    // en=0 dominates mode_scan and in_valid.
    step(0, 1, 1, 3'd3, 8'h00, 3'd0, 0, 0, 0);
    step(0, 0, 0, 3'd0, 8'h00, 3'd0, 0, 0, 0);

    // Scan run past one wrap up to code 6; stray load pulse ignored.
    for (int j = 0; j < 58; j++)
      step(1, 1, (j == 10), 3'd2, tbl[(j / 4) % 8], 3'((j / 4) % 8), 1,
           (j > 0 && j % 32 == 0), 0);

    // Scan exit holds code 6, then disable clears.
    step(1, 0, 0, 3'd0, 8'h02, 3'd6, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'd0, 8'h02, 3'd6, 1, 0, 1);
    step(0, 0, 0, 3'd0, 8'h00, 3'd0, 0, 0, 0);

    // Scan to code 4, then async reset between edges.
    for (int j = 0; j < 18; j++)
      step(1, 1, 0, 3'd0, tbl[(j / 4) % 8], 3'((j / 4) % 8), 1, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("async_out", {24'd0, out}, {24'd0, pol(8'h00)});
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_code", {29'd0, out_code}, 32'd0);
    #2;
    rst = 1'b0;
    x.o = pol(8'h80); x.c = 3'd0; x.v = 1'b1; x.w = 1'b0;
    q.push_back(x);
    @(posedge clk);
    for (int j = 1; j < 36; j++)
      step(1, 1, 0, 3'd0, tbl[(j / 4) % 8], 3'((j / 4) % 8), 1, (j % 32 == 0), 0);

    // Leave scan, then load code 2 from HOLD.
    step(1, 0, 0, 3'd0, tbl[0], 3'd0, 1, 0, 0);
    step(1, 0, 1, 3'd2, 8'h20, 3'd2, 1, 0, 1);

    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
